// File: rtl/pipe_hazard_unit_pkg.sv
// Shared encodings and the per-stage destination state for the MIPS hazard unit.
package pipe_hazard_unit_pkg;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } stage_t;

  // A stage produces r only if it writes a nonzero destination equal to r.
  function automatic logic hits(input stage_t s, input logic [4:0] r);
    return s.wreg && (s.rn != REG_ZERO) && (s.rn == r);
  endfunction

  // One operand's source select; a load still in EX cannot forward and falls through.
  function automatic logic [1:0] fwd_sel(input stage_t ex, input stage_t mem,
                                         input logic [4:0] r);
    logic [1:0] sel;
    sel = FWD_REG;
    if (hits(ex, r) && !ex.m2reg)
      sel = FWD_EXALU;
    else if (hits(mem, r))
      sel = mem.m2reg ? FWD_MEMLD : FWD_MEMALU;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// EX/MEM/WB destination tracking, forwarding selects, load-use stall, IF flush and counters.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [4:0]       id_rn,
  input  logic             id_jump,
  input  logic             id_branch,
  input  logic             RS_EQU_RT,
  output logic [1:0]       FWDA,
  output logic [1:0]       FWDB,
  output logic             WPCIR,
  output logic             ex_bubble,
  output logic             if_flush,
  output logic             e_wreg,
  output logic             e_m2reg,
  output logic [4:0]       e_rn,
  output logic             m_wreg,
  output logic             m_m2reg,
  output logic [4:0]       m_rn,
  output logic             w_wreg,
  output logic [4:0]       w_rn,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_t     id_s, ex_s, mem_s;
  logic       wb_wreg;
  logic [4:0] wb_rn;
  logic       stall, flush;

  assign id_s = '{wreg: id_wreg, m2reg: id_m2reg, rn: id_rn};

  // Reset forces the quiet output set so a hazard seen during reset has no effect.
  assign stall = !reset && ex_s.m2reg &&
                 ((uses_rs && hits(ex_s, rs)) || (uses_rt && hits(ex_s, rt)));
  assign flush = !reset && !stall && (id_jump || (id_branch && RS_EQU_RT));

  assign FWDA      = reset ? FWD_REG : fwd_sel(ex_s, mem_s, rs);
  assign FWDB      = reset ? FWD_REG : fwd_sel(ex_s, mem_s, rt);
  assign WPCIR     = !stall;
  assign ex_bubble = stall;
  assign if_flush  = flush;

  // A stalled cycle inserts an empty slot into EX while older stages keep draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_s    <= '0;
      mem_s   <= '0;
      wb_wreg <= 1'b0;
      wb_rn   <= REG_ZERO;
    end else begin
      ex_s    <= stall ? stage_t'('0) : id_s;
      mem_s   <= ex_s;
      wb_wreg <= mem_s.wreg;
      wb_rn   <= mem_s.rn;
    end
  end

  assign e_wreg  = ex_s.wreg;
  assign e_m2reg = ex_s.m2reg;
  assign e_rn    = ex_s.rn;
  assign m_wreg  = mem_s.wreg;
  assign m_m2reg = mem_s.m2reg;
  assign m_rn    = mem_s.rn;
  assign w_wreg  = wb_wreg;
  assign w_rn    = wb_rn;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: an in-flight instruction model checked every cycle plus literal pins.
module tb_pipe_hazard_unit;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rs, rt, id_rn;
  logic             uses_rs, uses_rt, id_wreg, id_m2reg, id_jump, id_branch, RS_EQU_RT;
  logic [1:0]       FWDA, FWDB;
  logic             WPCIR, ex_bubble, if_flush;
  logic             e_wreg, e_m2reg, m_wreg, m_m2reg, w_wreg;
  logic [4:0]       e_rn, m_rn, w_rn;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_rn(id_rn), .id_jump(id_jump),
    .id_branch(id_branch), .RS_EQU_RT(RS_EQU_RT), .FWDA(FWDA), .FWDB(FWDB),
    .WPCIR(WPCIR), .ex_bubble(ex_bubble), .if_flush(if_flush),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn),
    .w_wreg(w_wreg), .w_rn(w_rn), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct { int w; int m; int rn; } instr_t;
  instr_t fl[3];
  int     m_scnt, m_fcnt;
  bit     model_ok = 0;

  function automatic bit produces(input instr_t x, input int r);
    return x.w != 0 && x.rn != 0 && x.rn == r;
  endfunction

  function automatic bit exp_stall();
    if (reset) return 0;
    return fl[0].m != 0 &&
           ((uses_rs && produces(fl[0], int'(rs))) || (uses_rt && produces(fl[0], int'(rt))));
  endfunction

  function automatic bit exp_flush();
    if (reset) return 0;
    return !exp_stall() && (id_jump || (id_branch && RS_EQU_RT));
  endfunction

  function automatic int exp_fwd(input int r);
    if (reset) return 0;
    if (produces(fl[0], r) && fl[0].m == 0) return 1;
    if (produces(fl[1], r)) return (fl[1].m != 0) ? 3 : 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      foreach (fl[i]) fl[i] = '{0, 0, 0};
      m_scnt = 0; m_fcnt = 0; model_ok = 1;
    end else if (model_ok) begin
      if (exp_stall()) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
      if (exp_flush()) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
      fl[2] = fl[1];
      fl[1] = fl[0];
      fl[0] = exp_stall() ? '{0, 0, 0} : '{int'(id_wreg), int'(id_m2reg), int'(id_rn)};
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_fwda", FWDA, exp_fwd(int'(rs)));
      chk("m_fwdb", FWDB, exp_fwd(int'(rt)));
      chk("m_wpcir", WPCIR, !exp_stall());
      chk("m_bubble", ex_bubble, exp_stall());
      chk("m_flush", if_flush, exp_flush());
      chk("m_ex", {e_wreg, e_m2reg, e_rn}, (fl[0].w << 6) | (fl[0].m << 5) | fl[0].rn);
      chk("m_mem", {m_wreg, m_m2reg, m_rn}, (fl[1].w << 6) | (fl[1].m << 5) | fl[1].rn);
      chk("m_wb", {w_wreg, w_rn}, (fl[2].w << 5) | fl[2].rn);
      chk("m_scnt", stall_cnt, m_scnt);
      chk("m_fcnt", flush_cnt, m_fcnt);
    end
  end

  task automatic drv(input int a, input int b, input bit ua, input bit ub,
                     input bit w, input bit m, input int n,
                     input bit j, input bit br, input bit eq);
    rs = 5'(a); rt = 5'(b); uses_rs = ua; uses_rt = ub;
    id_wreg = w; id_m2reg = m; id_rn = 5'(n);
    id_jump = j; id_branch = br; RS_EQU_RT = eq;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (3) begin nop(); nxt(); end
  endtask

  initial begin
    reset = 1'b1;
    nop();
    nxt(); nxt();
    @(negedge clk);
    chk("rst_wpcir", WPCIR, 1);
    chk("rst_ex", e_wreg, 0);
    chk("rst_scnt", stall_cnt, 0);
    reset = 1'b0;
    nxt();

    // ALU -> ALU, distance 1
    drv(0, 0, 0, 0, 1, 0, 3, 0, 0, 0); nxt();
    drv(3, 0, 1, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("alu_fwda", FWDA, 1); chk("alu_wpcir", WPCIR, 1); chk("alu_bub", ex_bubble, 0);
    nxt();

    // distance 2: ALU then load producer
    drain();
    drv(0, 0, 0, 0, 1, 0, 5, 0, 0, 0); nxt();
    drv(0, 0, 0, 0, 1, 0, 7, 0, 0, 0); nxt();
    drv(0, 5, 0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("d2_fwdb_alu", FWDB, 2);
    nxt();
    drain();
    drv(0, 0, 0, 0, 1, 1, 5, 0, 0, 0); nxt();
    drv(0, 0, 0, 0, 1, 0, 7, 0, 0, 0); nxt();
    drv(0, 5, 0, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("d2_fwdb_ld", FWDB, 3); chk("d2_wpcir", WPCIR, 1);
    nxt();

    // load-use
    drain();
    drv(0, 0, 0, 0, 1, 1, 4, 0, 0, 0); nxt();
    drv(4, 0, 1, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("lu_wpcir", WPCIR, 0); chk("lu_bub", ex_bubble, 1);
    nxt();
    @(negedge clk);
    chk("lu2_wpcir", WPCIR, 1); chk("lu2_bub", ex_bubble, 0); chk("lu2_ex", e_wreg, 0);
    chk("lu2_fwda", FWDA, 3); chk("lu2_scnt", stall_cnt, 1);
    nxt();

    // r0 never matches
    drain();
    drv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); nxt();
    drv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("r0_fwda", FWDA, 0); chk("r0_wpcir", WPCIR, 1);
    nxt();
    drv(0, 0, 0, 0, 1, 1, 0, 0, 0, 0); nxt();
    drv(0, 0, 1, 1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("r0ld_wpcir", WPCIR, 1); chk("r0ld_fwda", FWDA, 0);
    nxt();

    // branch taken, then branch behind a load-use hazard
    drain();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); @(negedge clk);
    chk("br_flush", if_flush, 1);
    nxt();
    drv(0, 0, 0, 0, 1, 1, 6, 0, 0, 0); @(negedge clk);
    chk("br_fcnt", flush_cnt, 1);
    nxt();
    drv(6, 0, 1, 0, 0, 0, 0, 0, 1, 1); @(negedge clk);
    chk("brst_flush", if_flush, 0); chk("brst_wpcir", WPCIR, 0);
    nxt();
    @(negedge clk);
    chk("brst2_flush", if_flush, 1); chk("brst2_fwda", FWDA, 3);
    nxt();

    // four more load-use stalls: six total saturates a 2-bit counter at 3
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 0, 0, 1, 1, 8, 0, 0, 0); nxt();
      drv(0, 8, 0, 1, 0, 0, 0, 0, 0, 0); nxt();
      @(negedge clk);
      nxt();
    end
    @(negedge clk);
    chk("sat_scnt", stall_cnt, 3);

    // reset during a stall
    drv(0, 0, 0, 0, 1, 1, 9, 0, 0, 0); nxt();
    drv(9, 0, 1, 0, 0, 0, 0, 0, 1, 1); reset = 1'b1; @(negedge clk);
    chk("rs_wpcir", WPCIR, 1); chk("rs_bub", ex_bubble, 0); chk("rs_flush", if_flush, 0);
    nxt();
    reset = 1'b0; nop(); @(negedge clk);
    chk("rs2_wpcir", WPCIR, 1);
    chk("rs2_stages", {e_wreg, e_m2reg, e_rn, m_wreg, m_m2reg, m_rn, w_wreg, w_rn}, 0);
    chk("rs2_scnt", stall_cnt, 0); chk("rs2_fcnt", flush_cnt, 0);
    nxt();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); @(negedge clk);
    chk("jmp_flush", if_flush, 1);
    nxt();
    nop(); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Tracks destination-register state of in-flight instructions through the EX, MEM and WB stages of the 5-stage MIPS pipeline.
- Consumes the per-instruction control decoded in ID by the control unit.
- Produces the operand-forwarding selects FWDA/FWDB, the PC/IF-ID write enable WPCIR, the ID->EX bubble and the IF flush.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rs  in  5  ID-stage source register A.
- rt  in  5  ID-stage source register B.
- uses_rs  in  1  ID instruction reads rs.
- uses_rt  in  1  ID instruction reads rt.
- id_wreg  in  1  ID instruction writes the register file.
- id_m2reg  in  1  ID instruction is a load.
- id_rn  in  5  ID destination register, already resolved from the REGRT/JAL select.
- id_jump  in  1  ID instruction is J/JAL/JR.
- id_branch  in  1  ID instruction is a conditional branch.
- RS_EQU_RT  in  1  branch comparison result from ID.
- FWDA  out  2  operand A source select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data.
- FWDB  out  2  operand B source select; same encoding as FWDA.
- WPCIR  out  1  1 = PC and IF/ID update; 0 = hold (stall).
- ex_bubble  out  1  1 = inject NOP control into ID/EX this cycle.
- if_flush  out  1  1 = squash the instruction currently in IF.
- e_wreg, e_m2reg  out  1 each  EX-stage state.
- e_rn  out  5  EX-stage destination register.
- m_wreg, m_m2reg  out  1 each  MEM-stage state.
- m_rn  out  5  MEM-stage destination register.
- w_wreg  out  1  WB-stage write enable.
- w_rn  out  5  WB-stage destination register.
- stall_cnt  out  CNT_W  number of stall cycles.
- flush_cnt  out  CNT_W  number of flush cycles.

Behaviour:
- Reset (synchronous, active-high):
  - All e_/m_/w_ registers clear to 0.
  - Counters clear to 0.
  - Outputs in the reset cycle: WPCIR=1, FWDA=FWDB=00, ex_bubble=0, if_flush=0.
- Pipeline advance, every non-reset cycle:
  - EX <= ID (wreg, m2reg, rn).
  - MEM <= EX.
  - WB <= MEM.
  - When stalled, EX instead loads wreg=0, m2reg=0, rn=0. MEM and WB still advance.
- Matching rule: a stage is a producer for register r iff its wreg=1, its rn!=0 and rn==r. Register 0 never matches.
- Forwarding (combinational from current stage state; computed per operand, FWDB uses rt exactly as FWDA uses rs):
  - EX producer, not a load -> 01.
  - Else MEM producer, not a load -> 10.
  - Else MEM producer, load -> 11.
  - Else 00.
  - EX has priority over MEM.
  - A load producer in EX never forwards; it causes a stall instead.
  - WB needs no forwarding: the register file is write-through.
  - FWDA/FWDB are driven regardless of uses_rs/uses_rt.
- Load-use stall (combinational): stall = e_wreg & e_m2reg & e_rn!=0 & ((uses_rs & e_rn==rs) | (uses_rt & e_rn==rt)).
  - WPCIR = ~stall.
  - ex_bubble = stall.
  - A stall lasts exactly 1 cycle per load-use pair. The next cycle the load is in MEM and forwards with 11.
- Flush (combinational): if_flush = ~stall & (id_jump | (id_branch & RS_EQU_RT)).
  - Stall wins over flush. The branch is re-evaluated in the following cycle with forwarded operands.
- Counters:
  - stall_cnt increments on each stall cycle.
  - flush_cnt increments on each if_flush cycle.
  - Both saturate at all-ones, with no wrap.
  - Both are registered: the value updates the cycle after the event.
- Reset mid-stall or mid-flush: reset dominates. The next cycle presents an empty pipeline, with no residual stall.

Decomposition:
- Shared package holds the FWD encodings: FWD_REG=2'b00, FWD_EXALU=2'b01, FWD_MEMALU=2'b10, FWD_MEMLD=2'b11.
- Shared package also holds the REG_ZERO=5'd0 constant.
- One natural sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count). Instantiated twice.
- Forward-select logic is written once and applied to both operands, as a function or generate block.

Test Plan:
- ALU-to-ALU: add r3 with id_rn=3, id_wreg=1; next cycle rs=3, uses_rs=1 -> FWDA=01, WPCIR=1, no bubble.
- Distance-2: producer for r5, one unrelated instruction, then consumer with rt=5 -> FWDB=10. Same sequence with producer id_m2reg=1 -> FWDB=11.
- Load-use: load to r4, next cycle rs=4 -> WPCIR=0 and ex_bubble=1 for exactly 1 cycle, e_wreg=0 after it. Then FWDA=11 and stall_cnt=1.
- r0 immunity: producer with id_rn=0, id_wreg=1; consumer rs=0 -> FWDA=00 and no stall. Same for a load to r0.
- Branch/jump: id_branch=1, RS_EQU_RT=1 -> if_flush=1 and flush_cnt=1. With a simultaneous load-use hazard -> if_flush=0 and WPCIR=0; next cycle if_flush=1.
- Saturation/reset: CNT_W=2 with 5 stall events -> stall_cnt=3. Asserting reset during a stall -> next cycle WPCIR=1, all stage registers 0, counters 0.
